rv32i_core: RTL and testbench
=============================

// Module: rv32i_core
// PURPOSE
//  Single-cycle RV32I integer core: one instruction fetched, executed and retired per clk rising edge.
//  Top of the CPU hierarchy; contains the PC, the 32x32 register file, ALU/immediate logic,
//  and private instruction and data memories.
//  Benches preload the memories and registers hierarchically and observe them the same way.
// PARAMETERS
//  MEM_WORDS  1024  depth (32-bit words) of insn_memory and data_memory
//  RESET_PC   0     PC value while reset is asserted
// PORTS
//  clk    input  1  single clock; all state updates on the rising edge
//  reset  input  1  asynchronous, active-low reset
// BEHAVIOUR
//  Required names (benches probe these hierarchically):
//   - signals: pc, pc_in, instruction_mux_out, mux_a_out, mux_b_out, alu_out
//   - instances/arrays: register_file.regFile[0:31], insn_memory.mem[], data_memory.mem[]
//  Reset:
//   - reset low: pc forced to RESET_PC immediately (async); instruction_mux_out = NOP 0x00000013.
//   - Register file and both memories are NOT cleared by reset, so preloaded contents survive.
//  Fetch:
//   - insn_memory read is combinational, word index pc[11:2].
//   - instruction_mux_out = reset ? insn_memory word : NOP.
//  Register file:
//   - 2 combinational read ports; x0 reads 0.
//   - 1 write port on posedge; writes to x0 are dropped.
//  Execute:
//   - mux_a_out = rs1 value, or pc for AUIPC/JAL.
//   - mux_b_out = rs2 value, or sign-extended immediate (I/S/B/U/J formats per opcode).
//   - alu_out is a 32-bit result with wrap-around arithmetic.
//  ALU decode:
//   - funct3 selects ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
//   - insn[30] is consulted only for funct3=000 (SUB, OP only, not OP-IMM) and funct3=101 (SRA/SRAI).
//   - insn[30] is ignored for all other funct3, e.g. 0x4020F1B3 executes as AND x3,x1,x2.
//   - Shift amounts use the low 5 bits of the operand.
//  Opcodes supported:
//   - LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
//   - LB/LH/LW/LBU/LHU and SB/SH/SW.
//   - OP-IMM, OP.
//  Writeback and memory timing:
//   - rd is written on the same posedge that advances the PC.
//   - JAL/JALR write pc+4 to rd; JALR target clears bit 0.
//   - Loads: data_memory combinational read, byte/half extracted by addr[1:0] and sign/zero-extended.
//   - Stores: written at posedge with byte enables; misaligned accesses use addr[1:0] lanes, no trap.
//  Next PC:
//   - pc_in = pc+4, or branch/jump target when taken; pc <= pc_in each posedge.
//   - PC wraps modulo MEM_WORDS*4 for fetch indexing.
//  Unknown opcodes (including 0x00000000): no register write, no memory write, PC+4.
//   - No traps, no CSRs, FENCE/ECALL treated the same way.
// TESTING
//  1. Preload regFile[k]=k; pulse reset low 5-10ns -> pc=0 during reset; regFile still holds k afterwards.
//  2. Program 0x02A08093 (ADDI x1,x1,42), 0x01510113 (ADDI x2,x2,21), 0x4020F1B3 -> after 3 clk: x1=43, x2=23, x3=3.
//  3. Same run continues over zero words -> registers unchanged; pc advances by 4 each cycle (0x0C, 0x10, ...).
//  4. ADDI x0,x0,5 then ADD x4,x0,x0 -> x0 reads 0, x4=0.
//  5. SW x2,0(x0) with x2=0x12345678, then LB x5,1(x0) -> mem[0]=0x12345678, x5=0x56.
//  6. BEQ x1,x1,+8 -> pc skips one word; JAL x1,+16 at pc=0x20 -> x1=0x24, pc=0x30.

Source files
------------

// File: rtl/rv32i_core.sv
// rtl/rv32i_core.sv - single-cycle RV32I core with private instruction/data memories
//
// Purpose : fetches, executes and retires one RV32I instruction per rising clk edge.
//           Holds the PC, a 32x32 register file, immediate/ALU logic and two word memories.
// Ports   : clk   - single clock, all state updates on the rising edge
//           reset - asynchronous active-low reset; holds pc at RESET_PC and feeds a NOP
//
// Register file and memories have no reset so hierarchically preloaded contents survive.

module rv32i_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] wd,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);
    logic [31:0] regFile [0:31];

    assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regFile[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regFile[rs2_addr];

    always_ff @(posedge clk) begin
        if (we && (rd_addr != 5'd0)) begin
            regFile[rd_addr] <= wd;
        end
    end
endmodule

// Word memory: combinational read, byte-enabled synchronous write.
module rv32i_mem #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:WORDS-1];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

module rv32i_core #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic clk,
    input  logic reset
);
    localparam int          AW  = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc, pc_in, pc_plus4, branch_target;
    logic [31:0] insn_rdata, instruction_mux_out;
    logic [31:0] rs1_val, rs2_val, imm, mux_a_out, mux_b_out, alu_out;
    logic [31:0] dmem_rdata, dmem_wdata, load_shifted, load_data, wb_data;
    logic [3:0]  dmem_be;
    logic [1:0]  byte_off;
    logic [4:0]  shamt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        reg_we, dmem_we, branch_taken;

    rv32i_mem #(.WORDS(MEM_WORDS), .AW(AW)) insn_memory (
        .clk   (clk),
        .we    (1'b0),
        .be    (4'b0000),
        .addr  (pc[AW+1:2]),
        .wdata (32'h0),
        .rdata (insn_rdata)
    );

    assign instruction_mux_out = reset ? insn_rdata : NOP;
    assign opcode = instruction_mux_out[6:0];
    assign funct3 = instruction_mux_out[14:12];

    rv32i_regfile register_file (
        .clk      (clk),
        .we       (reg_we),
        .rs1_addr (instruction_mux_out[19:15]),
        .rs2_addr (instruction_mux_out[24:20]),
        .rd_addr  (instruction_mux_out[11:7]),
        .wd       (wb_data),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val)
    );

    always_comb begin
        imm = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
        case (opcode)
            OPC_STORE:  imm = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:25],
                               instruction_mux_out[11:7]};
            OPC_BRANCH: imm = {{19{instruction_mux_out[31]}}, instruction_mux_out[31],
                               instruction_mux_out[7], instruction_mux_out[30:25],
                               instruction_mux_out[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {instruction_mux_out[31:12], 12'h000};
            OPC_JAL:    imm = {{11{instruction_mux_out[31]}}, instruction_mux_out[31],
                               instruction_mux_out[19:12], instruction_mux_out[20],
                               instruction_mux_out[30:21], 1'b0};
            default:    imm = {{20{instruction_mux_out[31]}}, instruction_mux_out[31:20]};
        endcase
    end

    assign mux_a_out = ((opcode == OPC_AUIPC) || (opcode == OPC_JAL)) ? pc : rs1_val;
    assign mux_b_out = (opcode == OPC_OP) ? rs2_val : imm;
    assign shamt     = mux_b_out[4:0];

    // Non-ALU opcodes use the adder for addresses/targets; LUI passes the immediate through.
    always_comb begin
        alu_out = mux_a_out + mux_b_out;
        if (opcode == OPC_LUI) begin
            alu_out = mux_b_out;
        end else if ((opcode == OPC_OP) || (opcode == OPC_OPIMM)) begin
            case (funct3)
                3'b000: alu_out = ((opcode == OPC_OP) && instruction_mux_out[30]) ?
                                  mux_a_out - mux_b_out : mux_a_out + mux_b_out;
                3'b001: alu_out = mux_a_out << shamt;
                3'b010: alu_out = {31'b0, $signed(mux_a_out) < $signed(mux_b_out)};
                3'b011: alu_out = {31'b0, mux_a_out < mux_b_out};
                3'b100: alu_out = mux_a_out ^ mux_b_out;
                3'b101: alu_out = instruction_mux_out[30] ?
                                  32'($signed(mux_a_out) >>> shamt) : mux_a_out >> shamt;
                3'b110: alu_out = mux_a_out | mux_b_out;
                default: alu_out = mux_a_out & mux_b_out;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    // Data memory: lanes follow addr[1:0] even when misaligned; bytes shifted past lane 3 are lost.
    assign byte_off     = alu_out[1:0];
    assign dmem_we      = (opcode == OPC_STORE);
    assign dmem_wdata   = rs2_val << {byte_off, 3'b000};
    assign load_shifted = dmem_rdata >> {byte_off, 3'b000};

    always_comb begin
        case (funct3[1:0])
            2'b00:   dmem_be = 4'b0001 << byte_off;
            2'b01:   dmem_be = 4'b0011 << byte_off;
            default: dmem_be = 4'b1111 << byte_off;
        endcase
    end

    rv32i_mem #(.WORDS(MEM_WORDS), .AW(AW)) data_memory (
        .clk   (clk),
        .we    (dmem_we),
        .be    (dmem_be),
        .addr  (alu_out[AW+1:2]),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );

    always_comb begin
        case (funct3)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_data = {24'h0, load_shifted[7:0]};
            3'b101:  load_data = {16'h0, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP: reg_we = 1'b1;
            default:                     reg_we = 1'b0;
        endcase
    end

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc + imm;
    assign wb_data = ((opcode == OPC_JAL) || (opcode == OPC_JALR)) ? pc_plus4 :
                     (opcode == OPC_LOAD) ? load_data : alu_out;

    always_comb begin
        pc_in = pc_plus4;
        if (opcode == OPC_JAL) begin
            pc_in = alu_out;
        end else if (opcode == OPC_JALR) begin
            pc_in = {alu_out[31:1], 1'b0};
        end else if ((opcode == OPC_BRANCH) && branch_taken) begin
            pc_in = branch_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_in;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// tb/tb_rv32i_core.sv - self-checking bench for rv32i_core against an ISA-level model

module tb_rv32i_core;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rv32i_core #(.MEM_WORDS(1024), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ISA-level reference state
    logic [31:0] m_pc;
    logic [31:0] m_x    [0:31];
    logic [31:0] m_imem [0:1023];
    logic [31:0] m_dmem [0:1023];
    logic        model_en = 1'b0;
    logic        cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
        logic [31:0] a, b, c, d, e, g;
        a = f7; b = rs2; c = rs1; d = f3; e = rd; g = op;
        return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], g[6:0]};
    endfunction

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] a, c, d, e, g;
        a = imm; c = rs1; d = f3; e = rd; g = op;
        return {a[11:0], c[4:0], d[2:0], e[4:0], g[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] a, b, c, d;
        a = imm; b = rs2; c = rs1; d = f3;
        return {a[11:5], b[4:0], c[4:0], d[2:0], a[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] a, b, c, d;
        a = imm; b = rs2; c = rs1; d = f3;
        return {a[12], a[10:5], b[4:0], c[4:0], d[2:0], a[4:1], a[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        logic [31:0] a, e, g;
        a = imm20; e = rd; g = op;
        return {a[19:0], e[4:0], g[6:0]};
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] ea, int sz);
        logic [31:0] w, v;
        int lane;
        w = m_dmem[ea[11:2]];
        v = 32'h0;
        for (int k = 0; k < sz; k++) begin
            lane = int'(ea[1:0]) + k;
            if (lane < 4) v[8*k +: 8] = w[8*lane +: 8];
        end
        return v;
    endfunction

    task automatic m_store(input logic [31:0] ea, input logic [31:0] d, input int sz);
        logic [31:0] w;
        int lane;
        w = m_dmem[ea[11:2]];
        for (int k = 0; k < sz; k++) begin
            lane = int'(ea[1:0]) + k;
            if (lane < 4) w[8*lane +: 8] = d[8*k +: 8];
        end
        m_dmem[ea[11:2]] = w;
    endtask

    // Executes one instruction on the model state following the RV32I rules.
    task automatic model_step();
        logic [31:0] ins, a, b, opnd, immI, immS, immB, immU, immJ, nxt, val, ea;
        logic [4:0]  sh;
        logic        wr, take;
        int rd, f3, sz;
        ins  = m_imem[m_pc[11:2]];
        rd   = int'(ins[11:7]);
        f3   = int'(ins[14:12]);
        a    = m_x[ins[19:15]];
        b    = m_x[ins[24:20]];
        immI = {{20{ins[31]}}, ins[31:20]};
        immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        immU = {ins[31:12], 12'h000};
        immJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt  = m_pc + 4;
        wr   = 1'b0;
        val  = 32'h0;
        sz   = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        case (ins[6:0])
            7'h37: begin wr = 1'b1; val = immU; end
            7'h17: begin wr = 1'b1; val = m_pc + immU; end
            7'h6F: begin wr = 1'b1; val = m_pc + 4; nxt = m_pc + immJ; end
            7'h67: begin wr = 1'b1; val = m_pc + 4; nxt = (a + immI) & ~32'h1; end
            7'h63: begin
                case (f3)
                    0: take = (a == b);
                    1: take = (a != b);
                    4: take = ($signed(a) < $signed(b));
                    5: take = ($signed(a) >= $signed(b));
                    6: take = (a < b);
                    7: take = (a >= b);
                    default: take = 1'b0;
                endcase
                if (take) nxt = m_pc + immB;
            end
            7'h03: begin
                ea  = a + immI;
                val = m_load(ea, sz);
                if (f3 == 0 && val[7])  val = val | 32'hFFFF_FF00;
                if (f3 == 1 && val[15]) val = val | 32'hFFFF_0000;
                wr  = 1'b1;
            end
            7'h23: m_store(a + immS, b, sz);
            7'h13, 7'h33: begin
                opnd = (ins[6:0] == 7'h13) ? immI : b;
                sh   = opnd[4:0];
                case (f3)
                    0: val = (ins[6:0] == 7'h33 && ins[30]) ? a - opnd : a + opnd;
                    1: val = a << sh;
                    2: val = ($signed(a) < $signed(opnd)) ? 32'd1 : 32'd0;
                    3: val = (a < opnd) ? 32'd1 : 32'd0;
                    4: val = a ^ opnd;
                    5: val = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
                    6: val = a | opnd;
                    default: val = a & opnd;
                endcase
                wr = 1'b1;
            end
            default: ;
        endcase
        if (wr && rd != 0) m_x[rd] = val;
        m_pc = nxt;
    endtask

    always @(posedge clk) begin
        if (model_en) model_step();
    end

    // Per-cycle comparison of architectural state against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", dut.pc, m_pc);
            for (int k = 1; k < 32; k++)
                chk($sformatf("x%0d", k), dut.register_file.regFile[k], m_x[k]);
            for (int k = 0; k < 8; k++)
                chk($sformatf("dmem%0d", k), dut.data_memory.mem[k], m_dmem[k]);
        end
    end

    task automatic setreg(input int k, input logic [31:0] v);
        dut.register_file.regFile[k] = v;
        m_x[k] = (k == 0) ? 32'h0 : v;
    endtask

    // Holds reset low, loads program/registers/data into DUT and model.
    task automatic begin_test(input logic [31:0] prog[$]);
        logic [31:0] w;
        @(negedge clk);
        model_en = 1'b0;
        cmp_en   = 1'b0;
        reset    = 1'b0;
        #1;
        chk("pc_in_reset", dut.pc, 32'h0);
        for (int i = 0; i < 1024; i++) begin
            w = (i < prog.size()) ? prog[i] : 32'h0;
            dut.insn_memory.mem[i] = w;
            m_imem[i] = w;
            dut.data_memory.mem[i] = 32'h0;
            m_dmem[i] = 32'h0;
        end
        for (int k = 0; k < 32; k++) setreg(k, k);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset    = 1'b1;
        m_pc     = 32'h0;
        model_en = 1'b1;
        cmp_en   = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p[$];
        logic        regs_ok;
        reset = 1'b1;

        // Reset pulse mid-cycle with preloaded registers
        for (int k = 0; k < 32; k++) dut.register_file.regFile[k] = k;
        for (int i = 0; i < 1024; i++) begin
            dut.insn_memory.mem[i] = 32'h0;
            dut.data_memory.mem[i] = 32'h0;
        end
        #3 reset = 1'b0;
        #3;
        chk("reset_pc", dut.pc, 32'h0);
        chk("reset_nop", dut.instruction_mux_out, 32'h0000_0013);
        #4 reset = 1'b1;
        run(2);
        chk("pc_after_reset_2clk", dut.pc, 32'h8);
        regs_ok = 1'b1;
        for (int k = 1; k < 32; k++)
            if (dut.register_file.regFile[k] !== 32'(k)) regs_ok = 1'b0;
        chk("regs_survive_reset", {31'b0, regs_ok}, 32'h1);

        // ADDI/ADDI/AND-with-bit30, then run over zero words
        p = '{32'h02A08093, 32'h01510113, 32'h4020F1B3};
        begin_test(p);
        release_reset();
        run(3);
        chk("t2_x1", dut.register_file.regFile[1], 32'd43);
        chk("t2_x2", dut.register_file.regFile[2], 32'd23);
        chk("t2_x3", dut.register_file.regFile[3], 32'd3);
        chk("t3_pc_0c", dut.pc, 32'h0C);
        run(1);
        chk("t3_pc_10", dut.pc, 32'h10);
        chk("t3_x3_kept", dut.register_file.regFile[3], 32'd3);

        // x0 is hard-wired zero
        p = '{32'h00500013, 32'h00000233};
        begin_test(p);
        release_reset();
        run(2);
        chk("t4_x4", dut.register_file.regFile[4], 32'h0);

        // Store word then signed byte load
        p = '{32'h00202023, 32'h00100283};
        begin_test(p);
        setreg(2, 32'h12345678);
        release_reset();
        run(2);
        chk("t5_mem0", dut.data_memory.mem[0], 32'h12345678);
        chk("t5_x5", dut.register_file.regFile[5], 32'h56);

        // Taken BEQ, NOPs, then JAL at 0x20
        p = '{32'h00108463, 32'h0, 32'h13, 32'h13, 32'h13, 32'h13, 32'h13, 32'h13, 32'h010000EF};
        begin_test(p);
        release_reset();
        run(1);
        chk("t6_beq_pc", dut.pc, 32'h8);
        run(7);
        chk("t6_jal_pc", dut.pc, 32'h30);
        chk("t6_jal_x1", dut.register_file.regFile[1], 32'h24);

        // Mixed ALU, load/store, branch and jump program
        p = '{};
        p.push_back(enc_r(32, 2, 1, 0, 4, 'h33));
        p.push_back(enc_r(32, 2, 1, 5, 5, 'h33));
        p.push_back(enc_i('h404, 3, 5, 6, 'h13));
        p.push_back(enc_i(4, 3, 5, 7, 'h13));
        p.push_back(enc_r(0, 2, 1, 2, 8, 'h33));
        p.push_back(enc_r(0, 2, 1, 3, 9, 'h33));
        p.push_back(enc_u('hABCDE, 10, 'h37));
        p.push_back(enc_u(1, 11, 'h17));
        p.push_back(enc_i(-1, 1, 4, 12, 'h13));
        p.push_back(enc_s(6, 1, 0, 1));
        p.push_back(enc_i(6, 0, 5, 13, 'h03));
        p.push_back(enc_i(6, 0, 1, 14, 'h03));
        p.push_back(enc_s(3, 2, 0, 0));
        p.push_back(enc_i(0, 0, 2, 15, 'h03));
        p.push_back(enc_b(8, 2, 1, 4));
        p.push_back(enc_i(1, 0, 0, 16, 'h13));
        p.push_back(enc_b(8, 2, 1, 7));
        p.push_back(enc_i(1, 0, 0, 17, 'h13));
        p.push_back(enc_i(1, 19, 0, 18, 'h67));
        p.push_back(enc_i(7, 0, 0, 20, 'h13));
        p.push_back(enc_i(7, 0, 0, 20, 'h13));
        p.push_back(enc_b(8, 2, 2, 1));
        p.push_back(enc_i(31, 2, 1, 21, 'h13));
        p.push_back(enc_r(0, 2, 1, 6, 22, 'h33));
        p.push_back(enc_r(32, 1, 1, 7, 23, 'h33));
        p.push_back(enc_i(-3, 0, 0, 24, 'h13));
        begin_test(p);
        setreg(1, 32'hFFFF_FFF0);
        setreg(2, 32'd3);
        setreg(3, 32'h8000_0000);
        setreg(19, 32'd83);
        release_reset();
        run(24);
        chk("t7_sub",   dut.register_file.regFile[4],  32'hFFFF_FFED);
        chk("t7_sra",   dut.register_file.regFile[5],  32'hFFFF_FFFE);
        chk("t7_srai",  dut.register_file.regFile[6],  32'hF800_0000);
        chk("t7_srli",  dut.register_file.regFile[7],  32'h0800_0000);
        chk("t7_slt",   dut.register_file.regFile[8],  32'h1);
        chk("t7_sltu",  dut.register_file.regFile[9],  32'h0);
        chk("t7_lui",   dut.register_file.regFile[10], 32'hABCD_E000);
        chk("t7_auipc", dut.register_file.regFile[11], 32'h0000_101C);
        chk("t7_xori",  dut.register_file.regFile[12], 32'h0000_000F);
        chk("t7_lhu",   dut.register_file.regFile[13], 32'h0000_FFF0);
        chk("t7_lh",    dut.register_file.regFile[14], 32'hFFFF_FFF0);
        chk("t7_lw",    dut.register_file.regFile[15], 32'h0300_0000);
        chk("t7_blt_skip",  dut.register_file.regFile[16], 32'd16);
        chk("t7_bgeu_skip", dut.register_file.regFile[17], 32'd17);
        chk("t7_jalr_link", dut.register_file.regFile[18], 32'd76);
        chk("t7_jalr_skip", dut.register_file.regFile[20], 32'd20);
        chk("t7_slli",  dut.register_file.regFile[21], 32'h8000_0000);
        chk("t7_or",    dut.register_file.regFile[22], 32'hFFFF_FFF3);
        chk("t7_and30", dut.register_file.regFile[23], 32'hFFFF_FFF0);
        chk("t7_addi30", dut.register_file.regFile[24], 32'hFFFF_FFFD);
        chk("t7_sh_mem1", dut.data_memory.mem[1], 32'hFFF0_0000);
        chk("t7_pc", dut.pc, 32'h70);

        cmp_en   = 1'b0;
        model_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
